// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with exact occupancy level, programmable almost-full/almost-empty
// thresholds and registered flags. Optional sticky error flags under FIFO_ERR_FLAGS_EN.
module sync_fifo_level #(
  parameter int DATA_WIDTH    = 8,
  parameter int SIZE_LOG2     = 5,
  parameter int AFULL_THRESH  = (2 ** SIZE_LOG2) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_write_en,
  input  logic [DATA_WIDTH-1:0] p_write_data,
  output logic                  p_write_full,
  output logic                  p_almost_full,
  input  logic                  p_read_en,
  output logic [DATA_WIDTH-1:0] p_read_data,
  output logic                  p_read_valid,
  output logic                  p_read_empty,
  output logic                  p_almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  p_overflow,
  output logic                  p_underflow,
`endif
  output logic [SIZE_LOG2:0]    p_level
);

  localparam int DEPTH = 2 ** SIZE_LOG2;
  localparam int LW    = SIZE_LOG2 + 1;
  localparam logic [SIZE_LOG2:0] DEPTH_L = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [SIZE_LOG2:0]    wptr;
  logic [SIZE_LOG2:0]    rptr;
  logic [SIZE_LOG2:0]    level_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Handshake: a request is taken on a rising edge when its enable is high and the
  // registered full (write) or empty (read) flag is low; otherwise it is dropped.
  // Accepted read data appears with p_read_valid exactly one cycle later.
  assign wr_acc = p_write_en & ~p_write_full;
  assign rd_acc = p_read_en & ~p_read_empty;

  always_comb begin
    level_next = p_level;
    case ({wr_acc, rd_acc})
      2'b10:   level_next = p_level + 1'b1;
      2'b01:   level_next = p_level - 1'b1;
      default: level_next = p_level;
    endcase
  end

  // Storage is never cleared; after reset the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wptr[SIZE_LOG2-1:0]] <= p_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr           <= '0;
      rptr           <= '0;
      p_level        <= '0;
      p_write_full   <= 1'b0;
      p_read_empty   <= 1'b1;
      p_almost_empty <= 1'b1;
      p_almost_full  <= (AFULL_THRESH == 0);
      p_read_valid   <= 1'b0;
      p_read_data    <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr        <= rptr + 1'b1;
        p_read_data <= mem[rptr[SIZE_LOG2-1:0]];
      end
      p_read_valid <= rd_acc;
      // Flags come from the next level so they line up with the registered p_level.
      p_level        <= level_next;
      p_write_full   <= (level_next == DEPTH_L);
      p_read_empty   <= (level_next == '0);
      p_almost_full  <= (int'(level_next) >= AFULL_THRESH);
      p_almost_empty <= (int'(level_next) <= AEMPTY_THRESH);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      p_overflow  <= 1'b0;
      p_underflow <= 1'b0;
    end else begin
      if (p_write_en && p_write_full) p_overflow  <= 1'b1;
      if (p_read_en && p_read_empty)  p_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed bench for sync_fifo_level at depth 8 (SIZE_LOG2=3), thresholds 6 / 2.
// Error-flag checks compile in when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_level;

  localparam int DW = 8;
  localparam int SL = 3;
  localparam int LW = SL + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [DW-1:0] wd;
  logic          rd;
  logic          full;
  logic          afull;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          empty;
  logic          aempty;
  logic [SL:0]   level;
`ifdef FIFO_ERR_FLAGS_EN
  logic          ovf;
  logic          udf;
`endif

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] exp_q[$];

  sync_fifo_level #(
    .DATA_WIDTH(DW), .SIZE_LOG2(SL), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .p_write_en(wr), .p_write_data(wd), .p_write_full(full), .p_almost_full(afull),
    .p_read_en(rd), .p_read_data(rdata), .p_read_valid(rvalid),
    .p_read_empty(empty), .p_almost_empty(aempty),
`ifdef FIFO_ERR_FLAGS_EN
    .p_overflow(ovf), .p_underflow(udf),
`endif
    .p_level(level)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wd = '0;
    cyc(); cyc();
    rst = 1'b0;
    repeat (5) cyc();
    total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
    total++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
    total++; if (aempty !== 1'b1) $display("FAIL reset_aempty: got %b want 1", aempty); else passed++;
    total++; if (afull !== 1'b0) $display("FAIL reset_afull: got %b want 0", afull); else passed++;
    total++; if (rvalid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rvalid); else passed++;
    total++; if (rdata !== 8'h00) $display("FAIL reset_data: got %h want 00", rdata); else passed++;
`ifdef FIFO_ERR_FLAGS_EN
    total++; if ({ovf, udf} !== 2'b00) $display("FAIL reset_err: got %b want 00", {ovf, udf}); else passed++;
`endif
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wd = DW'(i); exp_q.push_back(DW'(i));
      cyc();
      total++; if (level !== LW'(i + 1)) $display("FAIL fill_level: got %0d want %0d", level, i + 1); else passed++;
    end
    total++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else passed++;
    total++; if (afull !== 1'b1) $display("FAIL fill_afull: got %b want 1", afull); else passed++;
    wd = 8'hFF;
    cyc();
    wr = 1'b0;
    total++; if (level !== 4'd8) $display("FAIL overwrite_level: got %0d want 8", level); else passed++;
    total++; if (full !== 1'b1) $display("FAIL overwrite_full: got %b want 1", full); else passed++;
`ifdef FIFO_ERR_FLAGS_EN
    total++; if (ovf !== 1'b1) $display("FAIL overflow_flag: got %b want 1", ovf); else passed++;
`endif
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1;
      cyc();
      e = exp_q.pop_front();
      total++; if (rvalid !== 1'b1) $display("FAIL drain_valid: got %b want 1", rvalid); else passed++;
      total++; if (rdata !== e) $display("FAIL drain_data: got %h want %h", rdata, e); else passed++;
      total++; if (level !== LW'(7 - i)) $display("FAIL drain_level: got %0d want %0d", level, 7 - i); else passed++;
    end
    rd = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else passed++;
    cyc();
    total++; if (rvalid !== 1'b0) $display("FAIL idle_valid: got %b want 0", rvalid); else passed++;
    total++; if (rdata !== 8'h07) $display("FAIL hold_data: got %h want 07", rdata); else passed++;
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wd = DW'(8'h10 + i);
      cyc();
    end
    total++; if (full !== 1'b1) $display("FAIL fs_full_before: got %b want 1", full); else passed++;
    wd = 8'h99; rd = 1'b1;
    cyc();
    wr = 1'b0; rd = 1'b0;
    total++; if (rvalid !== 1'b1) $display("FAIL fs_valid: got %b want 1", rvalid); else passed++;
    total++; if (rdata !== 8'h10) $display("FAIL fs_data: got %h want 10", rdata); else passed++;
    total++; if (level !== 4'd7) $display("FAIL fs_level: got %0d want 7", level); else passed++;
    total++; if (full !== 1'b0) $display("FAIL fs_full_after: got %b want 0", full); else passed++;
    for (int i = 0; i < 7; i++) begin
      rd = 1'b1;
      cyc();
      total++; if (rdata !== DW'(8'h11 + i)) $display("FAIL fs_drain_data: got %h want %h", rdata, DW'(8'h11 + i)); else passed++;
    end
    rd = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL fs_empty: got %b want 1", empty); else passed++;
  endtask

  task automatic test_empty_simul();
    wr = 1'b1; wd = 8'hA5; rd = 1'b1;
    cyc();
    wr = 1'b0; rd = 1'b0;
    total++; if (level !== 4'd1) $display("FAIL es_level: got %0d want 1", level); else passed++;
    total++; if (rvalid !== 1'b0) $display("FAIL es_valid: got %b want 0", rvalid); else passed++;
    total++; if (empty !== 1'b0) $display("FAIL es_empty: got %b want 0", empty); else passed++;
    total++; if (rdata !== 8'h17) $display("FAIL es_hold_data: got %h want 17", rdata); else passed++;
`ifdef FIFO_ERR_FLAGS_EN
    total++; if (udf !== 1'b1) $display("FAIL underflow_flag: got %b want 1", udf); else passed++;
`endif
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    total++; if (rdata !== 8'hA5) $display("FAIL es_data: got %h want a5", rdata); else passed++;
    total++; if (rvalid !== 1'b1) $display("FAIL es_valid2: got %b want 1", rvalid); else passed++;
    total++; if (level !== 4'd0) $display("FAIL es_level2: got %0d want 0", level); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL es_empty2: got %b want 1", empty); else passed++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    for (int i = 0; i < 40; i++) begin
      d = DW'(i * 37 + 5);
      wr = 1'b1; wd = d; exp_q.push_back(d);
      cyc();
      wr = 1'b0;
      total++; if (level !== 4'd1) $display("FAIL wrap_level1: got %0d want 1 (pair %0d)", level, i); else passed++;
      rd = 1'b1;
      cyc();
      rd = 1'b0;
      e = exp_q.pop_front();
      total++; if (rdata !== e || rvalid !== 1'b1) $display("FAIL wrap_data: got %h/%b want %h/1 (pair %0d)", rdata, rvalid, e, i); else passed++;
      total++; if (level !== 4'd0) $display("FAIL wrap_level0: got %0d want 0 (pair %0d)", level, i); else passed++;
    end
  endtask

  task automatic test_thresholds();
    for (int k = 1; k <= 8; k++) begin
      wr = 1'b1; wd = DW'(k);
      cyc();
      total++; if (aempty !== (k <= 2)) $display("FAIL thr_up_aempty: got %b at level %0d", aempty, k); else passed++;
      total++; if (afull !== (k >= 6)) $display("FAIL thr_up_afull: got %b at level %0d", afull, k); else passed++;
    end
    wr = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      rd = 1'b1;
      cyc();
      total++; if (aempty !== (k <= 2)) $display("FAIL thr_dn_aempty: got %b at level %0d", aempty, k); else passed++;
      total++; if (afull !== (k >= 6)) $display("FAIL thr_dn_afull: got %b at level %0d", afull, k); else passed++;
    end
    rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wd = DW'(8'h50 + i);
      cyc();
    end
    wr = 1'b0;
    total++; if (level !== 4'd5) $display("FAIL rm_level_before: got %0d want 5", level); else passed++;
    rst = 1'b1; wr = 1'b1; wd = 8'hEE; rd = 1'b1;
    cyc();
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    total++; if (level !== 4'd0) $display("FAIL rm_level: got %0d want 0", level); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rm_empty: got %b want 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL rm_full: got %b want 0", full); else passed++;
    total++; if (aempty !== 1'b1) $display("FAIL rm_aempty: got %b want 1", aempty); else passed++;
    total++; if (rvalid !== 1'b0 || rdata !== 8'h00) $display("FAIL rm_read: got %b/%h want 0/00", rvalid, rdata); else passed++;
`ifdef FIFO_ERR_FLAGS_EN
    total++; if ({ovf, udf} !== 2'b00) $display("FAIL rm_err: got %b want 00", {ovf, udf}); else passed++;
`endif
    wr = 1'b1; wd = 8'h3C;
    cyc();
    wr = 1'b0;
    total++; if (level !== 4'd1) $display("FAIL rm_post_level: got %0d want 1", level); else passed++;
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    total++; if (rdata !== 8'h3C || rvalid !== 1'b1) $display("FAIL rm_post_data: got %h/%b want 3c/1", rdata, rvalid); else passed++;
    total++; if (level !== 4'd0) $display("FAIL rm_post_level0: got %0d want 0", level); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_empty_simul();
    test_wrap();
    test_thresholds();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
